// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Learns from resolved branches and gives a same-cycle prediction for the fetch PC.
//
// branch_predict_i layout, MSB first (133 bits):
//   valid, pc[63:0], target_address[63:0], is_mispredict, is_taken, is_lower_16, clear
// branch_predict_o layout, MSB first (67 bits):
//   valid, predict_address[63:0], predict_taken, is_lower_16
module branch_target_buffer #(
  parameter int NR_ENTRIES              = 8,
  parameter int BITS_SATURATION_COUNTER = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic [63:0]  vpc_i,
  input  logic [132:0] branch_predict_i,
  output logic [66:0]  branch_predict_o
);

  localparam int IDX   = $clog2(NR_ENTRIES);
  localparam int TAG_W = 64 - IDX - 1;
  localparam int CNT_W = BITS_SATURATION_COUNTER;

  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN     = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WEAK_NOT_TAKEN = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX            = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN            = {CNT_W{1'b0}};

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    logic        is_lower_16;
    logic        clear;
  } branchpredict_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        is_lower_16;
  } branchpredict_sbe_t;

  branchpredict_t     bp;
  branchpredict_sbe_t pred;

  // Per-line state
  logic             valid_q  [NR_ENTRIES];
  logic             valid_d  [NR_ENTRIES];
  logic [TAG_W-1:0] tag_q    [NR_ENTRIES];
  logic [TAG_W-1:0] tag_d    [NR_ENTRIES];
  logic [63:0]      target_q [NR_ENTRIES];
  logic [63:0]      target_d [NR_ENTRIES];
  logic [CNT_W-1:0] cnt_q    [NR_ENTRIES];
  logic [CNT_W-1:0] cnt_d    [NR_ENTRIES];
  logic             lower_q  [NR_ENTRIES];
  logic             lower_d  [NR_ENTRIES];

  logic [IDX-1:0]   lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic             lookup_hit;
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // Bit 0 of a PC is always zero for 2-byte aligned code; mispredict only informs.
  logic unused_bits;
  assign unused_bits = ^{bp.is_mispredict, bp.pc[0], vpc_i[0]};

  assign bp               = branchpredict_t'(branch_predict_i);
  assign branch_predict_o = pred;

  assign lookup_idx = vpc_i[IDX:1];
  assign lookup_tag = vpc_i[63:IDX+1];
  assign upd_idx    = bp.pc[IDX:1];
  assign upd_tag    = bp.pc[63:IDX+1];

  assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Zero-latency lookup: prediction fields are forced to zero on a miss
  always_comb begin
    pred = '0;
    if (lookup_hit) begin
      pred.valid           = 1'b1;
      pred.predict_address = target_q[lookup_idx];
      pred.predict_taken   = cnt_q[lookup_idx][CNT_W-1];
      pred.is_lower_16     = lower_q[lookup_idx];
    end
  end

  // Next-state for all lines: flush beats training, clear beats allocate/train
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      cnt_d[i]    = cnt_q[i];
      lower_d[i]  = lower_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (bp.valid) begin
      if (bp.clear) begin
        valid_d[upd_idx] = 1'b0;
      end else if (!upd_hit) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bp.target_address;
        lower_d[upd_idx]  = bp.is_lower_16;
        cnt_d[upd_idx]    = bp.is_taken ? CNT_WEAK_TAKEN : CNT_WEAK_NOT_TAKEN;
      end else if (bp.is_taken) begin
        target_d[upd_idx] = bp.target_address;
        lower_d[upd_idx]  = bp.is_lower_16;
        if (cnt_q[upd_idx] != CNT_MAX) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
        end
      end else begin
        if (cnt_q[upd_idx] != CNT_MIN) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - 1'b1;
        end
      end
    end
  end

  // Line storage with asynchronous clear of every field
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        lower_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
        lower_q[i]  <= lower_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed lookups push expected
// predictions, a negedge monitor pops and compares.
module tb_branch_target_buffer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic [63:0]  vpc_i;
  logic [132:0] branch_predict_i;
  logic [66:0]  branch_predict_o;

  typedef struct {
    logic [66:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   testsRun  = 0;
  int   failCount = 0;
  bit   lookupValid = 1'b0;

  branch_target_buffer #(.NR_ENTRIES(8), .BITS_SATURATION_COUNTER(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .vpc_i            (vpc_i),
    .branch_predict_i (branch_predict_i),
    .branch_predict_o (branch_predict_o)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  function automatic logic [66:0] mkExp(input logic v, input logic [63:0] addr,
                                        input logic taken, input logic lower);
    return {v, addr, taken, lower};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setUpd(input logic [63:0] pc, input logic [63:0] tgt,
                        input logic taken, input logic lower, input logic clr);
    branch_predict_i = {1'b1, pc, tgt, 1'b1, taken, lower, clr};
  endtask

  // Idle resolution with non-zero fields that must be ignored
  task automatic noUpd();
    branch_predict_i = {1'b0, 64'h10, 64'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0};
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [66:0] exp, input string name);
    exp_t e;
    vpc_i  = pc;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
    lookupValid = 1'b1;
  endtask

  task automatic checkOutput();
    exp_t e;
    testsRun++;
    if (sbq.size() == 0) begin
      failCount++;
      $display("[TB] FAIL no_expectation actual=%h", branch_predict_o);
    end else begin
      e = sbq.pop_front();
      if (branch_predict_o !== e.exp) begin
        failCount++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, branch_predict_o, e.exp);
      end
    end
  endtask

  // Monitor: compare whenever a lookup was presented this cycle
  always @(negedge clk_i) begin
    if (lookupValid) begin
      checkOutput();
      lookupValid = 1'b0;
    end
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    noUpd();
    applyStimulus(64'h8000_0000, '0, "reset_held");
    tick();
    tick();
    rst_ni = 1'b1;
    applyStimulus(64'h8000_0000, '0, "reset_released");
    tick();

    // Allocate taken, then hit next cycle
    setUpd(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h8000_0010, '0, "alloc_same_cycle");
    tick();
    noUpd();
    applyStimulus(64'h8000_0010, mkExp(1'b1, 64'h8000_0100, 1'b1, 1'b1), "alloc_hit");
    tick();

    // Counter saturation on pc 0x20; each lookup sees the previous update
    setUpd(64'h20, 64'h300, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h20, '0, "sat_before_alloc");
    tick();
    setUpd(64'h20, 64'h999, 1'b0, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h300, 1'b0, 1'b0), "sat_cnt01");
    tick();
    setUpd(64'h20, 64'h999, 1'b0, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h300, 1'b0, 1'b0), "sat_cnt00");
    tick();
    setUpd(64'h20, 64'h340, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h300, 1'b0, 1'b0), "sat_cnt00_hold");
    tick();
    setUpd(64'h20, 64'h340, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b0, 1'b1), "sat_cnt01_up");
    tick();
    setUpd(64'h20, 64'h340, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b1, 1'b1), "sat_cnt10_up");
    tick();
    setUpd(64'h20, 64'h340, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b1, 1'b1), "sat_cnt11");
    tick();
    setUpd(64'h20, 64'h999, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b1, 1'b1), "sat_cnt11_hold");
    tick();
    setUpd(64'h20, 64'h999, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b1, 1'b1), "sat_cnt10_down");
    tick();
    noUpd();
    applyStimulus(64'h20, mkExp(1'b1, 64'h340, 1'b0, 1'b1), "sat_cnt01_down");
    tick();

    // Aliasing: 0x10 and 0x1010 share index 0
    setUpd(64'h10, 64'h500, 1'b1, 1'b0, 1'b0);
    tick();
    setUpd(64'h1010, 64'h2000, 1'b1, 1'b0, 1'b0);
    applyStimulus(64'h10, mkExp(1'b1, 64'h500, 1'b1, 1'b0), "alias_first_hit");
    tick();
    noUpd();
    applyStimulus(64'h10, '0, "alias_evicted");
    tick();
    applyStimulus(64'h1010, mkExp(1'b1, 64'h2000, 1'b1, 1'b0), "alias_second_hit");
    tick();

    // Clear a single line
    setUpd(64'h10, 64'h500, 1'b1, 1'b0, 1'b0);
    tick();
    setUpd(64'h10, 64'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(64'h10, mkExp(1'b1, 64'h500, 1'b1, 1'b0), "clear_before");
    tick();
    noUpd();
    applyStimulus(64'h10, '0, "clear_after");
    tick();

    // Fill all lines, then flush with a simultaneous update to 0x4
    for (int i = 0; i < 8; i++) begin
      setUpd(64'(i * 2), 64'(32'h1000 + i * 2), 1'b1, 1'b0, 1'b0);
      tick();
    end
    noUpd();
    applyStimulus(64'hE, mkExp(1'b1, 64'h100E, 1'b1, 1'b0), "fill_hit");
    tick();
    flush_i = 1'b1;
    setUpd(64'h4, 64'h4444, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h4, mkExp(1'b1, 64'h1004, 1'b1, 1'b0), "flush_cycle_old");
    tick();
    flush_i = 1'b0;
    noUpd();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(64'(i * 2), '0, $sformatf("flush_line%0d", i));
      tick();
    end

    // Refill, then asynchronous reset pulse between clock edges
    for (int i = 0; i < 8; i++) begin
      setUpd(64'(i * 2), 64'(32'h1000 + i * 2), 1'b1, 1'b0, 1'b0);
      tick();
    end
    noUpd();
    applyStimulus(64'h6, mkExp(1'b1, 64'h1006, 1'b1, 1'b0), "refill_hit");
    tick();
    applyStimulus(64'h6, '0, "async_reset_drop");
    #1 rst_ni = 1'b0;
    #6 rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(64'(i * 2), '0, $sformatf("post_reset_line%0d", i));
      tick();
    end

    // Drain: every expectation must have been consumed
    repeat (3) tick();
    if (sbq.size() != 0 || lookupValid) begin
      failCount++;
      testsRun++;
      $display("[TB] FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer (BTB) in the fetch stage. It is the consumer of the branchpredict resolution struct that the EX-stage branch unit produces.
- It learns from resolved branches and returns, in the same cycle, a branchpredict_sbe hint for the current fetch PC.
- The hint travels with the fetch_entry into the scoreboard.
- Entry state per line: valid, tag, target, 2-bit saturating direction counter, is_lower_16.

Parameters:
- NR_ENTRIES, 8 (BTB_ENTRIES): number of BTB lines; power of two, ≥2.
- BITS_SATURATION_COUNTER, 2: width of the per-entry direction counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate every entry
- vpc_i  in  64  virtual PC of the current fetch
- branch_predict_i  in  branchpredict (133)  resolution from the branch unit
- branch_predict_o  out  branchpredict_sbe (67)  prediction for vpc_i

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- Values while rst_ni=0, for all entries:
  - valid=0, tag=0, target=0, counter=0, is_lower_16=0.
  - branch_predict_o is therefore all-zero (valid=0).
- Addressing, with IDX=$clog2(NR_ENTRIES) and instructions 2-byte aligned (offset bit 0 ignored):
  - index = pc[IDX:1]
  - tag = pc[63:IDX+1]
- Lookup is purely combinational, with zero latency from vpc_i:
  - hit = entry[index(vpc_i)].valid AND tag equal.
  - branch_predict_o.valid = hit.
  - predict_taken = hit AND counter MSB.
  - predict_address = entry target when hit, else 0.
  - is_lower_16 = entry bit when hit, else 0.
- Update is sampled on a clk_i edge when branch_predict_i.valid=1; the entry is selected by index(branch_predict_i.pc).
  - clear=1: entry.valid←0; all other fields are unchanged.
  - Miss (invalid entry or tag differs): allocate/replace.
    - valid←1, tag←tag(pc), target←target_address, is_lower_16←is_lower_16.
    - counter←2'b10 if is_taken, else 2'b01.
  - Hit:
    - is_taken=1: counter saturating increment (max 2'b11); target←target_address; is_lower_16 updated.
    - is_taken=0: counter saturating decrement (min 2'b00); target unchanged.
  - is_mispredict is informational only. Every valid resolution trains the BTB regardless of that bit.
- No bypass. An update becomes visible on branch_predict_o from the cycle after the edge that captured it. A lookup of the same index in the update cycle returns the old contents.
- Flush:
  - flush_i=1 at an edge clears valid for all entries.
  - Flush has priority over a simultaneous update; that update is dropped.
  - Counters, tags and targets are left stale; they are unobservable while invalid.
- Aliasing: two PCs with equal index but different tags evict each other. A single line never holds two tags.
- Reset asserted mid-operation: all state clears immediately (asynchronously); no partial update survives.
- branch_predict_i fields other than valid are don't-care when valid=0; no state changes.

Test Plan:
- Reset/empty:
  - Stimulus: rst_ni=0, then release; vpc_i=0x8000_0000.
  - Required: branch_predict_o==0 throughout.
- Allocate taken, then hit:
  - Stimulus: update pc=0x8000_0010, target=0x8000_0100, is_taken=1, is_lower_16=1.
  - Required: next cycle, vpc_i=0x8000_0010 gives valid=1, predict_taken=1, predict_address=0x8000_0100, is_lower_16=1. The same-cycle lookup still shows valid=0.
- Counter saturation:
  - Stimulus: allocate pc=0x20 not-taken (counter 01).
  - Two more not-taken updates: counter 00, predict_taken=0.
  - Then three taken updates: counter 01, 10 (predict_taken=1), 11. A fourth taken update holds at 11.
  - Then one not-taken update: counter 10, still taken.
- Aliasing:
  - Stimulus: allocate pc=0x10 taken, then pc=0x1010 (same index, different tag) taken with target 0x2000.
  - Required: lookup 0x10 gives valid=0; lookup 0x1010 gives target 0x2000.
- Clear and flush:
  - Stimulus: clear=1 on pc=0x10. Required: next-cycle lookup valid=0.
  - Stimulus: fill 8 entries, then assert flush_i together with a valid update to pc=0x4. Required: every lookup valid=0, including pc=0x4.
- Asynchronous reset mid-stream:
  - Stimulus: fill entries, then pulse rst_ni low between clock edges.
  - Required: branch_predict_o drops to 0 without waiting for a clock edge, and all entries remain invalid afterwards.
